fwd_track: RTL and testbench
============================

# fwd_track

Parametrised bypass tracker for the pipelined datapath. Replaces fixed per-operand forwarding selection and separate HI/LO forwarding with one block. It records every in-flight register write in a DEPTH-entry shift pipeline and resolves NPORTS read ports against it, youngest match first. It supports paired 64-bit HI/LO writes, loads whose data arrives late, stall freeze, and load-use hazard detection. It sits beside the register file, and its outputs feed the ID-stage and EX-stage operand selects.

## Interface
- DATA_W, 32, register data width
- REG_AW, 6, register address width (0–31 GPR, 32 HI, 33 LO, 34 product pair)
- DEPTH, 3, number of tracked in-flight stages (≥2)
- NPORTS, 2, number of read ports
- FILL_IDX, 1, entry index at which late (load) data is filled (1 ≤ FILL_IDX < DEPTH)
- HI_ADDR, 32, address served by upper half of a pair entry
- LO_ADDR, 33, address served by lower half of a pair entry
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  freeze all entries; the new write is ignored
- wr_valid  in  1  new in-flight write enters e[0]
- wr_addr  in  REG_AW  destination; ignored when wr_pair=1
- wr_pair  in  1  write is a 64-bit HI/LO product
- wr_ready  in  1  data valid now (0 = load, filled later)
- wr_data  in  2*DATA_W  [DATA_W-1:0] normal/LO data, [2*DATA_W-1:DATA_W] HI data
- fill_valid  in  1  late data for the entry at e[FILL_IDX]
- fill_data  in  DATA_W  late data
- rd_addr  in  NPORTS*REG_AW  port p at [p*REG_AW +: REG_AW]
- rf_data  in  NPORTS*DATA_W  register file read data per port
- fwd_data  out  NPORTS*DATA_W  resolved operand per port
- fwd_hit  out  NPORTS  port p was served from an entry
- hazard  out  NPORTS  youngest match is not ready
- err  out  1  sticky protocol error

## Operation
- Entry fields: valid, pair, ready, addr, data[2*DATA_W].
- Match rules:
  - A non-pair entry matches rd_addr == addr.
  - A pair entry matches rd_addr == HI_ADDR, returning data[2*DATA_W-1:DATA_W], or rd_addr == LO_ADDR, returning data[DATA_W-1:0].
  - rd_addr == 0 never matches.
- Resolution per port, combinational:
  - The lowest-index valid matching entry wins.
  - If the winner is ready: fwd_hit=1, hazard=0, fwd_data = the winner's data.
  - If the winner is not ready: hazard=1, fwd_hit=0, fwd_data=rf_data.
  - With no match: fwd_hit=0, hazard=0, fwd_data=rf_data.
- Shift at each rising edge when stall=0:
  - e[i] ← e[i-1] for i ≥ 1.
  - e[0] ← {wr_valid, wr_pair, wr_ready, wr_addr, wr_data}.
  - e[DEPTH-1] retires, meaning the register file captures it on the same edge.
- stall=1: all entries hold, and wr_* is ignored.
- Fill at the edge:
  - Condition: fill_valid=1 and e[FILL_IDX] is valid, non-ready and non-pair.
  - Effect: the entry's data[DATA_W-1:0] ← fill_data and ready ← 1.
  - The updated entry moves to e[FILL_IDX+1] if stall=0, or stays in e[FILL_IDX] if stall=1.
- Error conditions; err is set and held until rst:
  - fill_valid=1 while e[FILL_IDX] is not a valid, pending, non-pair entry.
  - A non-ready valid entry retires from e[DEPTH-1] with stall=0.
  - wr_valid=1 with wr_pair=1 and wr_ready=0.
- Errors never alter entry contents beyond the rules above.

## Timing
- Reset (rst=1 at edge) has priority over stall and fill.
  - All entries: valid=0, ready=0, data=0. err=0.
  - Outputs after reset: fwd_data=rf_data, fwd_hit=0, hazard=0.
- Forward latency: a write presented with wr_valid at edge k is visible on fwd_data from after edge k until it retires at edge k+DEPTH (stall cycles extend this).
- A fill at edge k is visible from after edge k. fill_data is not forwarded combinationally in the cycle of the fill.
- Simultaneous write and read of the same address in one cycle: the read sees the older entries only. The new write is visible next cycle.
- A retiring entry still forwards during its last cycle in e[DEPTH-1].

## Test plan
- Basic forward:
  - Stimulus: reset; write addr 5, data 0x1234 (ready).
  - Port0 reads 5 for 3 cycles: fwd_hit=1, data 0x1234. Cycle 4: fwd_hit=0, data = rf_data.
- Youngest wins: write addr 7 = 0xA, then addr 7 = 0xB next cycle; read 7 → 0xB. Port1 reading 0 with an addr-0 write → rf_data, hit 0.
- Pair write: wr_pair with data 0xDEADBEEF_00C0FFEE; read 32 → 0xDEADBEEF, read 33 → 0x00C0FFEE, read 34 → no hit.
- Load-use:
  - Stimulus: write addr 9 with wr_ready=0.
  - Read 9 → hazard=1 until the fill edge. Fill 0x55 when the entry reaches e[1]; next cycle read 9 → hit, 0x55, hazard 0.
- Stall:
  - With entries loaded, hold stall=1 for 4 cycles while wr_valid=1 with addr 3. Entries are unchanged and addr 3 is never tracked.
  - Release the stall: the remaining lifetime is unchanged.
- Errors and reset:
  - fill_valid with e[1] empty → err=1 next cycle, and it stays high. A pending entry retiring → err=1.
  - Assert rst mid-stream → all hits 0 and err=0 after the edge.

Source files
------------

// File: rtl/fwd_track.sv
// fwd_track: bypass tracker for the pipelined datapath.
// Every in-flight register write is recorded in a DEPTH-entry shift
// pipeline. NPORTS read ports are resolved against it, and the youngest
// match wins. The tracker also handles paired HI/LO writes, late load
// data, stall freeze and load-use hazards.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             freeze all entries; the incoming write is dropped
//   wr_valid/addr/pair/ready/data   new write entering e[0]
//   fill_valid/data   late load data for the entry at e[FILL_IDX]
//   rd_addr, rf_data  per-port read address and register file data
//   fwd_data, fwd_hit, hazard       per-port resolved operand and status
//   err               sticky protocol error
module fwd_track #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 6,
   parameter int DEPTH    = 3,
   parameter int NPORTS   = 2,
   parameter int FILL_IDX = 1,
   parameter int HI_ADDR  = 32,
   parameter int LO_ADDR  = 33
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       wr_valid,
   input  logic [REG_AW-1:0]          wr_addr,
   input  logic                       wr_pair,
   input  logic                       wr_ready,
   input  logic [2*DATA_W-1:0]        wr_data,
   input  logic                       fill_valid,
   input  logic [DATA_W-1:0]          fill_data,
   input  logic [NPORTS*REG_AW-1:0]   rd_addr,
   input  logic [NPORTS*DATA_W-1:0]   rf_data,
   output logic [NPORTS*DATA_W-1:0]   fwd_data,
   output logic [NPORTS-1:0]          fwd_hit,
   output logic [NPORTS-1:0]          hazard,
   output logic                       err
);

   localparam logic [REG_AW-1:0] HI_A = REG_AW'(HI_ADDR);
   localparam logic [REG_AW-1:0] LO_A = REG_AW'(LO_ADDR);

   logic                valid_reg [DEPTH];
   logic                pair_reg  [DEPTH];
   logic                ready_reg [DEPTH];
   logic [REG_AW-1:0]   addr_reg  [DEPTH];
   logic [2*DATA_W-1:0] data_reg  [DEPTH];

   // Entry view with the pending fill applied. This view is used only for
   // the next state. Reads use the raw registers, so fill data is not
   // forwarded in the cycle it arrives.
   logic                ready_next [DEPTH];
   logic [2*DATA_W-1:0] data_next  [DEPTH];
   logic                fill_ok;
   logic                err_reg;

   assign fill_ok = fill_valid && valid_reg[FILL_IDX] &&
                    !ready_reg[FILL_IDX] && !pair_reg[FILL_IDX];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         if (gi == FILL_IDX) begin : g_fill
            assign ready_next[gi] = ready_reg[gi] | fill_ok;
            assign data_next[gi]  = fill_ok ? {data_reg[gi][2*DATA_W-1:DATA_W], fill_data}
                                            : data_reg[gi];
         end else begin : g_pass
            assign ready_next[gi] = ready_reg[gi];
            assign data_next[gi]  = data_reg[gi];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
               pair_reg[gi]  <= 1'b0;
               ready_reg[gi] <= 1'b0;
               addr_reg[gi]  <= '0;
               data_reg[gi]  <= '0;
            end else if (stall) begin
               // Hold the entry. Only a fill can update it in place.
               ready_reg[gi] <= ready_next[gi];
               data_reg[gi]  <= data_next[gi];
            end else begin
               if (gi == 0) begin
                  valid_reg[gi] <= wr_valid;
                  pair_reg[gi]  <= wr_pair;
                  ready_reg[gi] <= wr_ready;
                  addr_reg[gi]  <= wr_addr;
                  data_reg[gi]  <= wr_data;
               end else begin
                  valid_reg[gi] <= valid_reg[gi-1];
                  pair_reg[gi]  <= pair_reg[gi-1];
                  ready_reg[gi] <= ready_next[gi-1];
                  addr_reg[gi]  <= addr_reg[gi-1];
                  data_reg[gi]  <= data_next[gi-1];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if ((fill_valid && !fill_ok) ||
                   (!stall && valid_reg[DEPTH-1] && !ready_next[DEPTH-1]) ||
                   (wr_valid && wr_pair && !wr_ready)) begin
         err_reg <= 1'b1;
      end
   end
   assign err = err_reg;

   generate
      for (gi = 0; gi < NPORTS; gi++) begin : g_port
         logic [REG_AW-1:0] ra;
         logic              win_hit;
         logic              win_ready;
         logic [DATA_W-1:0] win_data;

         assign ra = rd_addr[gi*REG_AW +: REG_AW];

         // Scan from the oldest entry to the youngest. Each later match
         // overrides the earlier one, so the lowest index wins.
         always_comb begin
            win_hit   = 1'b0;
            win_ready = 1'b0;
            win_data  = '0;
            for (int i = DEPTH-1; i >= 0; i--) begin
               if (valid_reg[i] && (ra != '0)) begin
                  if (pair_reg[i]) begin
                     if (ra == HI_A) begin
                        win_hit   = 1'b1;
                        win_ready = ready_reg[i];
                        win_data  = data_reg[i][2*DATA_W-1:DATA_W];
                     end else if (ra == LO_A) begin
                        win_hit   = 1'b1;
                        win_ready = ready_reg[i];
                        win_data  = data_reg[i][DATA_W-1:0];
                     end
                  end else if (ra == addr_reg[i]) begin
                     win_hit   = 1'b1;
                     win_ready = ready_reg[i];
                     win_data  = data_reg[i][DATA_W-1:0];
                  end
               end
            end
         end

         assign fwd_hit[gi] = win_hit && win_ready;
         assign hazard[gi]  = win_hit && !win_ready;
         assign fwd_data[gi*DATA_W +: DATA_W] = (win_hit && win_ready) ? win_data
                                              : rf_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

endmodule

// File: tb/tb_fwd_track.sv
// Directed testbench for fwd_track. It uses the default parameters
// (DEPTH=3, FILL_IDX=1, two read ports). Each task drives one scenario and
// checks the outputs 1 ns after the rising edge.
module tb_fwd_track;
   logic        clk = 1'b0;
   logic        rst, stall, wr_valid, wr_pair, wr_ready, fill_valid;
   logic [5:0]  wr_addr;
   logic [63:0] wr_data;
   logic [31:0] fill_data;
   logic [5:0]  rd0, rd1;
   logic [31:0] rf0, rf1;
   logic [63:0] fwd_data;
   logic [1:0]  fwd_hit, hazard;
   logic        err;
   logic [31:0] fd0, fd1;

   int assertions = 0;
   int failures   = 0;

   always #5 clk = ~clk;

   fwd_track dut (
      .clk(clk), .rst(rst), .stall(stall),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_pair(wr_pair),
      .wr_ready(wr_ready), .wr_data(wr_data),
      .fill_valid(fill_valid), .fill_data(fill_data),
      .rd_addr({rd1, rd0}), .rf_data({rf1, rf0}),
      .fwd_data(fwd_data), .fwd_hit(fwd_hit), .hazard(hazard), .err(err)
   );

   assign fd0 = fwd_data[31:0];
   assign fd1 = fwd_data[63:32];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; wr_valid = 0; wr_pair = 0; wr_ready = 1; wr_addr = 0;
      wr_data = 0; fill_valid = 0; fill_data = 0;
   endtask

   task automatic flush();
      idle_inputs();
      repeat (3) step();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; step(); rst = 0; #1;
   endtask

   task automatic test_reset();
      rd0 = 5; rd1 = 9;
      do_reset();
      assertions++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL reset_hit: got %b expected 00", fwd_hit); end
      assertions++; if (hazard !== 2'b00) begin failures++; $display("FAIL reset_hazard: got %b expected 00", hazard); end
      assertions++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
      assertions++; if (fd0 !== rf0) begin failures++; $display("FAIL reset_data: got %h expected %h", fd0, rf0); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      wr_valid = 1; wr_addr = 5; wr_data = 64'h1234; wr_ready = 1;
      step();
      idle_inputs(); rd0 = 5; #1;
      for (int c = 1; c <= 3; c++) begin
         assertions++; if (fwd_hit[0] !== 1'b1 || fd0 !== 32'h1234) begin failures++; $display("FAIL basic_fwd_c%0d: got hit=%b data=%h expected hit=1 data=00001234", c, fwd_hit[0], fd0); end
         step();
      end
      assertions++; if (fwd_hit[0] !== 1'b0 || fd0 !== rf0) begin failures++; $display("FAIL basic_retired: got hit=%b data=%h expected hit=0 data=%h", fwd_hit[0], fd0, rf0); end
      $display("test_basic done");
   endtask

   task automatic test_youngest();
      flush();
      rd0 = 7; rd1 = 0;
      wr_valid = 1; wr_addr = 7; wr_data = 64'hA; step();
      wr_data = 64'hB; #1;
      // same-cycle write of B: the read still sees the older A
      assertions++; if (fd0 !== 32'hA || fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL same_cycle: got hit=%b data=%h expected hit=1 data=0000000a", fwd_hit[0], fd0); end
      step();
      wr_addr = 0; wr_data = 64'h99; step();
      idle_inputs(); #1;
      assertions++; if (fd0 !== 32'hB || fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL youngest: got hit=%b data=%h expected hit=1 data=0000000b", fwd_hit[0], fd0); end
      assertions++; if (fd1 !== rf1 || fwd_hit[1] !== 1'b0) begin failures++; $display("FAIL addr_zero: got hit=%b data=%h expected hit=0 data=%h", fwd_hit[1], fd1, rf1); end
      $display("test_youngest done");
   endtask

   task automatic test_pair();
      flush();
      wr_valid = 1; wr_pair = 1; wr_ready = 1; wr_addr = 34; wr_data = 64'hDEADBEEF_00C0FFEE;
      step();
      idle_inputs(); rd0 = 32; rd1 = 33; #1;
      assertions++; if (fd0 !== 32'hDEADBEEF || fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL pair_hi: got hit=%b data=%h expected hit=1 data=deadbeef", fwd_hit[0], fd0); end
      assertions++; if (fd1 !== 32'h00C0FFEE || fwd_hit[1] !== 1'b1) begin failures++; $display("FAIL pair_lo: got hit=%b data=%h expected hit=1 data=00c0ffee", fwd_hit[1], fd1); end
      rd0 = 34; #1;
      assertions++; if (fd0 !== rf0 || fwd_hit[0] !== 1'b0) begin failures++; $display("FAIL pair_34: got hit=%b data=%h expected hit=0 data=%h", fwd_hit[0], fd0, rf0); end
      $display("test_pair done");
   endtask

   task automatic test_load_use();
      flush();
      rd0 = 9; rd1 = 0;
      wr_valid = 1; wr_addr = 9; wr_ready = 0; wr_data = 64'h0;
      step();                            // entry in e[0]
      idle_inputs(); #1;
      assertions++; if (hazard[0] !== 1'b1 || fwd_hit[0] !== 1'b0 || fd0 !== rf0) begin failures++; $display("FAIL load_hazard_e0: got hz=%b hit=%b data=%h expected hz=1 hit=0 data=%h", hazard[0], fwd_hit[0], fd0, rf0); end
      step();                            // entry in e[1]
      fill_valid = 1; fill_data = 32'h55; #1;
      assertions++; if (hazard[0] !== 1'b1 || fd0 !== rf0) begin failures++; $display("FAIL load_fill_cycle: got hz=%b data=%h expected hz=1 data=%h", hazard[0], fd0, rf0); end
      step();                            // filled entry now in e[2]
      idle_inputs(); #1;
      assertions++; if (fwd_hit[0] !== 1'b1 || hazard[0] !== 1'b0 || fd0 !== 32'h55) begin failures++; $display("FAIL load_filled: got hit=%b hz=%b data=%h expected hit=1 hz=0 data=00000055", fwd_hit[0], hazard[0], fd0); end
      step();                            // retires ready
      assertions++; if (err !== 1'b0) begin failures++; $display("FAIL load_no_err: got %b expected 0", err); end
      $display("test_load_use done");
   endtask

   task automatic test_stall();
      flush();
      rd0 = 11; rd1 = 12;
      wr_valid = 1; wr_ready = 1; wr_addr = 11; wr_data = 64'h11; step();
      wr_addr = 12; wr_data = 64'h12; step();
      stall = 1; wr_addr = 3; wr_data = 64'h33; #1;
      for (int c = 0; c < 4; c++) begin
         rd1 = 12; #1;
         assertions++; if (fd0 !== 32'h11 || fd1 !== 32'h12) begin failures++; $display("FAIL stall_hold_c%0d: got %h/%h expected 00000011/00000012", c, fd0, fd1); end
         step();
      end
      idle_inputs(); rd1 = 3; #1;
      assertions++; if (fwd_hit[1] !== 1'b0) begin failures++; $display("FAIL stall_dropped: got hit=%b expected 0", fwd_hit[1]); end
      rd1 = 12;
      step();
      assertions++; if (fwd_hit !== 2'b11) begin failures++; $display("FAIL stall_release1: got %b expected 11", fwd_hit); end
      step();
      assertions++; if (fwd_hit !== 2'b10) begin failures++; $display("FAIL stall_release2: got %b expected 10", fwd_hit); end
      step();
      assertions++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL stall_release3: got %b expected 00", fwd_hit); end
      $display("test_stall done");
   endtask

   task automatic test_errors();
      flush();
      assertions++; if (err !== 1'b0) begin failures++; $display("FAIL err_clean: got %b expected 0", err); end
      fill_valid = 1; fill_data = 32'h77; step();
      idle_inputs(); #1;
      assertions++; if (err !== 1'b1) begin failures++; $display("FAIL err_bad_fill: got %b expected 1", err); end
      step(); step();
      assertions++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
      do_reset();
      wr_valid = 1; wr_addr = 9; wr_ready = 0; step();
      idle_inputs(); step(); step();
      assertions++; if (err !== 1'b0) begin failures++; $display("FAIL err_before_retire: got %b expected 0", err); end
      step();
      assertions++; if (err !== 1'b1) begin failures++; $display("FAIL err_pending_retire: got %b expected 1", err); end
      do_reset();
      wr_valid = 1; wr_pair = 1; wr_ready = 0; step();
      idle_inputs(); #1;
      assertions++; if (err !== 1'b1) begin failures++; $display("FAIL err_pair_not_ready: got %b expected 1", err); end
      rd0 = 5; wr_valid = 1; wr_addr = 5; wr_data = 64'h5A5A; step();
      idle_inputs(); #1;
      assertions++; if (fwd_hit[0] !== 1'b1) begin failures++; $display("FAIL pre_reset_hit: got %b expected 1", fwd_hit[0]); end
      rst = 1; step(); rst = 0; #1;
      assertions++; if (fwd_hit !== 2'b00 || err !== 1'b0 || fd0 !== rf0) begin failures++; $display("FAIL mid_reset: got hit=%b err=%b data=%h expected hit=00 err=0 data=%h", fwd_hit, err, fd0, rf0); end
      $display("test_errors done");
   endtask

   initial begin
      rf0 = 32'hF0F0_0000; rf1 = 32'h1111_2222;
      rst = 1; rd0 = 0; rd1 = 0;
      idle_inputs();
      test_reset();
      test_basic();
      test_youngest();
      test_pair();
      test_load_use();
      test_stall();
      test_errors();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
